// File: rtl/sequencer.sv
// Fetch/decode/execute control sequencer for the basic processor.
// The state, the halted flag and the retired-instruction counter are registered.
// The strobes are decoded combinationally (Mealy) from state, op, z_flag and mem_ready.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  FETCH0   | idle / start of instruction; PC -> MAR, PC++ when run=1
//  FETCH1   | instruction read; waits on mem_ready, then loads IR
//  DECODE   | IR address -> MAR for memory ops; HALT branches off here
//  EXEC     | operation; memory ops wait on mem_ready, INC/BNE take 1 cycle
//  HALT     | terminal; no strobes, left only through reset
module sequencer #(
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             z_flag,
  input  logic             mem_ready,
  input  logic             run,
  output logic             ACC_bus,
  output logic             load_ACC,
  output logic             ALU_ACC,
  output logic             ALU_add,
  output logic             ALU_sub,
  output logic             ALU_xor,
  output logic             ALU_inc,
  output logic             PC_bus,
  output logic             load_PC,
  output logic             INC_PC,
  output logic             load_IR,
  output logic             IR_bus,
  output logic             load_MAR,
  output logic             CS,
  output logic             R_NW,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    ST_FETCH0,
    ST_FETCH1,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_INC   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;

  assign halted    = halted_q;
  assign instr_cnt = instr_cnt_q;

  // Next-state and strobe decode; reset gates every strobe so nothing
  // partial (e.g. a load_ACC) can leak out while reset is high.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    retire   = 1'b0;
    ACC_bus  = 1'b0;
    load_ACC = 1'b0;
    ALU_ACC  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    ALU_xor  = 1'b0;
    ALU_inc  = 1'b0;
    PC_bus   = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_IR  = 1'b0;
    IR_bus   = 1'b0;
    load_MAR = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;

    unique case (state_q)
      ST_FETCH0: begin
        if (run) begin
          PC_bus   = 1'b1;
          load_MAR = 1'b1;
          INC_PC   = 1'b1;
          state_d  = ST_FETCH1;
        end
      end
      ST_FETCH1: begin
        CS   = 1'b1;
        R_NW = 1'b1;
        if (mem_ready) begin
          load_IR = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op == OP_HALT) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          retire   = 1'b1;
        end else begin
          if (op != OP_INC && op != OP_BNE) begin
            IR_bus   = 1'b1;
            load_MAR = 1'b1;
          end
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op)
          OP_LOAD: begin
            CS       = 1'b1;
            R_NW     = 1'b1;
            load_ACC = mem_ready;
            retire   = mem_ready;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            CS       = 1'b1;
            R_NW     = 1'b1;
            ALU_ACC  = 1'b1;
            ALU_add  = (op == OP_ADD);
            ALU_sub  = (op == OP_SUB);
            ALU_xor  = (op == OP_XOR);
            load_ACC = mem_ready;
            retire   = mem_ready;
          end
          OP_STORE: begin
            CS      = 1'b1;
            ACC_bus = 1'b1;
            retire  = mem_ready;
          end
          OP_INC: begin
            load_ACC = 1'b1;
            ALU_ACC  = 1'b1;
            ALU_inc  = 1'b1;
            retire   = 1'b1;
          end
          OP_BNE: begin
            IR_bus  = ~z_flag;
            load_PC = ~z_flag;
            retire  = 1'b1;
          end
          default: retire = 1'b1;
        endcase
        if (retire) state_d = ST_FETCH0;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH0;
    endcase

    instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;

    if (reset) begin
      ACC_bus  = 1'b0;
      load_ACC = 1'b0;
      ALU_ACC  = 1'b0;
      ALU_add  = 1'b0;
      ALU_sub  = 1'b0;
      ALU_xor  = 1'b0;
      ALU_inc  = 1'b0;
      PC_bus   = 1'b0;
      load_PC  = 1'b0;
      INC_PC   = 1'b0;
      load_IR  = 1'b0;
      IR_bus   = 1'b0;
      load_MAR = 1'b0;
      CS       = 1'b0;
      R_NW     = 1'b0;
    end
  end

  // State, halted flag and retired-instruction counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH0;
      halted_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer: strobe sequences per opcode, mem_ready
// stalls, BNE both ways, HALT, reset mid-instruction, counter wrap on a
// 2-bit-counter instance, and bus/ALU exclusivity over a random opcode run.
module tb_sequencer;

  localparam logic [14:0] S_ACC_BUS  = 15'h4000;
  localparam logic [14:0] S_LOAD_ACC = 15'h2000;
  localparam logic [14:0] S_ALU_ACC  = 15'h1000;
  localparam logic [14:0] S_ADD      = 15'h0800;
  localparam logic [14:0] S_SUB      = 15'h0400;
  localparam logic [14:0] S_XOR      = 15'h0200;
  localparam logic [14:0] S_INC      = 15'h0100;
  localparam logic [14:0] S_PC_BUS   = 15'h0080;
  localparam logic [14:0] S_LOAD_PC  = 15'h0040;
  localparam logic [14:0] S_INC_PC   = 15'h0020;
  localparam logic [14:0] S_LOAD_IR  = 15'h0010;
  localparam logic [14:0] S_IR_BUS   = 15'h0008;
  localparam logic [14:0] S_LOAD_MAR = 15'h0004;
  localparam logic [14:0] S_CS       = 15'h0002;
  localparam logic [14:0] S_RNW      = 15'h0001;

  localparam logic [14:0] E_F0  = S_PC_BUS | S_LOAD_MAR | S_INC_PC;
  localparam logic [14:0] E_F1  = S_CS | S_RNW | S_LOAD_IR;
  localparam logic [14:0] E_DEC = S_IR_BUS | S_LOAD_MAR;
  localparam logic [14:0] E_ARI = S_CS | S_RNW | S_LOAD_ACC | S_ALU_ACC;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic        z_flag, mem_ready, run;
  wire  [14:0] strb;
  wire  [14:0] strb2;
  wire         halted, halted2;
  wire  [15:0] instr_cnt;
  wire  [1:0]  instr_cnt2;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clock = ~clock;

  sequencer #(.OP_W(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag),
    .mem_ready(mem_ready), .run(run),
    .ACC_bus(strb[14]), .load_ACC(strb[13]), .ALU_ACC(strb[12]),
    .ALU_add(strb[11]), .ALU_sub(strb[10]), .ALU_xor(strb[9]), .ALU_inc(strb[8]),
    .PC_bus(strb[7]), .load_PC(strb[6]), .INC_PC(strb[5]), .load_IR(strb[4]),
    .IR_bus(strb[3]), .load_MAR(strb[2]), .CS(strb[1]), .R_NW(strb[0]),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  sequencer #(.OP_W(3), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag),
    .mem_ready(mem_ready), .run(run),
    .ACC_bus(strb2[14]), .load_ACC(strb2[13]), .ALU_ACC(strb2[12]),
    .ALU_add(strb2[11]), .ALU_sub(strb2[10]), .ALU_xor(strb2[9]), .ALU_inc(strb2[8]),
    .PC_bus(strb2[7]), .load_PC(strb2[6]), .INC_PC(strb2[5]), .load_IR(strb2[4]),
    .IR_bus(strb2[3]), .load_MAR(strb2[2]), .CS(strb2[1]), .R_NW(strb2[0]),
    .halted(halted2), .instr_cnt(instr_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check strobes mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [14:0] exp);
    @(negedge clock);
    chk(tag, 32'(strb), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input string tag, input logic [2:0] o,
                       input logic [14:0] dec, input logic [14:0] ex);
    op = o;
    cyc({tag, "_f0"}, E_F0);
    cyc({tag, "_f1"}, E_F1);
    cyc({tag, "_dec"}, dec);
    cyc({tag, "_exec"}, ex);
    exp_cnt++;
    chk({tag, "_cnt"}, 32'(instr_cnt), 32'(exp_cnt));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; op = 3'b010; z_flag = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_strobes", 32'(strb), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_strobes_hold", 32'(strb), 32'h0);
    chk("rst_cnt", 32'(instr_cnt), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;

    instr("add", 3'b010, E_DEC, E_ARI | S_ADD);

    run = 1'b0;
    cyc("idle_run0", 15'h0);
    cyc("idle_run0_b", 15'h0);
    chk("idle_cnt", 32'(instr_cnt), 32'(exp_cnt));
    run = 1'b1;

    op = 3'b001;
    cyc("st_f0", E_F0);
    cyc("st_f1", E_F1);
    cyc("st_dec", E_DEC);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("st_wait", S_CS | S_ACC_BUS);
    mem_ready = 1'b1;
    cyc("st_done", S_CS | S_ACC_BUS);
    exp_cnt++;
    chk("st_cnt", 32'(instr_cnt), 32'(exp_cnt));

    z_flag = 1'b0;
    instr("bne_z0", 3'b110, 15'h0, S_IR_BUS | S_LOAD_PC);
    z_flag = 1'b1;
    op = 3'b110;
    cyc("bne_z1_f0", E_F0);
    cyc("bne_z1_f1", E_F1);
    cyc("bne_z1_dec", 15'h0);
    mem_ready = 1'b0;
    cyc("bne_z1_exec", 15'h0);
    mem_ready = 1'b1;
    exp_cnt++;
    chk("bne_z1_cnt", 32'(instr_cnt), 32'(exp_cnt));
    z_flag = 1'b0;

    instr("load", 3'b000, E_DEC, S_CS | S_RNW | S_LOAD_ACC);
    instr("sub", 3'b011, E_DEC, E_ARI | S_SUB);

    op = 3'b100;
    cyc("xor_f0", E_F0);
    mem_ready = 1'b0;
    cyc("xor_f1_wait", S_CS | S_RNW);
    mem_ready = 1'b1;
    cyc("xor_f1", E_F1);
    cyc("xor_dec", E_DEC);
    mem_ready = 1'b0;
    cyc("xor_exec_wait", S_CS | S_RNW | S_ALU_ACC | S_XOR);
    mem_ready = 1'b1;
    cyc("xor_exec", E_ARI | S_XOR);
    exp_cnt++;
    chk("xor_cnt", 32'(instr_cnt), 32'(exp_cnt));

    op = 3'b010;
    cyc("ra_f0", E_F0);
    cyc("ra_f1", E_F1);
    cyc("ra_dec", E_DEC);
    mem_ready = 1'b0;
    cyc("ra_exec_wait", S_CS | S_RNW | S_ALU_ACC | S_ADD);
    reset = 1'b1;
    #1;
    chk("ra_rst_strobes", 32'(strb), 32'h0);
    chk("ra_rst_cnt", 32'(instr_cnt), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    exp_cnt = 0;
    cyc("ra_post_f0", E_F0);
    chk("ra_post_cnt", 32'(instr_cnt), 32'h0);

    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i != 2);
      op = 3'b101;
      cyc("inc_f0", E_F0);
      mem_ready = 1'b1;
      cyc("inc_f1", E_F1);
      cyc("inc_dec", 15'h0);
      mem_ready = (i != 3);
      cyc("inc_exec", S_LOAD_ACC | S_ALU_ACC | S_INC);
      mem_ready = 1'b1;
    end
    exp_cnt = 5;
    chk("inc_cnt16", 32'(instr_cnt), 32'd5);
    chk("inc_cnt2_wrap", 32'(instr_cnt2), 32'd1);

    op = 3'b111;
    cyc("halt_f0", E_F0);
    cyc("halt_f1", E_F1);
    cyc("halt_dec", 15'h0);
    exp_cnt++;
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_cnt", 32'(instr_cnt), 32'(exp_cnt));
    for (int i = 0; i < 20; i++) begin
      op = 3'(i);
      cyc("halt_idle", 15'h0);
    end
    chk("halt_flag_hold", 32'(halted), 32'h1);
    chk("halt_cnt_hold", 32'(instr_cnt), 32'(exp_cnt));
    chk("halt_cnt2", 32'(instr_cnt2), 32'd2);

    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 0) pulse_reset();
      op        = 3'($urandom_range(0, 7));
      z_flag    = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      run       = ($urandom_range(0, 7) != 0);
      @(negedge clock);
      chk("bus_excl", 32'($countones({strb[14], strb[7], strb[3], strb[1] & strb[0]}) <= 1), 32'h1);
      chk("alu_onehot", 32'($countones(strb[11:8]) <= 1), 32'h1);
      @(posedge clock);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
